// File: rtl/prog_pkg.sv
// Shared definitions for the programmable phase sequencer: FSM state
// encoding and the width rule for the whole-program unit counter.
package prog_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_END   = 2'd3
    } state_t;

    // Program total can reach NPH * (2^UW - 1), so UW plus enough bits to count NPH.
    function automatic int calc_tw(input int nph, input int uw);
        return uw + $clog2(nph + 1);
    endfunction

endpackage

// File: rtl/prog_seq_tick_gen.sv
// Unit timebase: counts 0..CMAX-1 and flags the last count as a wrap.
// clr wins over hold; wrap is combinational so the caller acts on the same edge.
module tick_gen #(
    parameter int CMAX = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hold,
    output logic wrap
);

    localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    // wrap deliberately ignores clr so that clr may depend on wrap without a loop.
    assign wrap = !hold && (cnt_reg == CW'(CMAX - 1));

    // Next count: clear, freeze, or advance with rollover.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (!hold) begin
            cnt_next = wrap ? '0 : cnt_reg + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/prog_seq.sv
// Programmable phase sequencer: runs the enabled, non-zero-length phases in
// ascending index order, one unit (TIM_CMAX clocks) at a time, with pause,
// abort and a timed end-wait that can be acknowledged early.
module prog_seq
    import prog_pkg::*;
#(
    parameter int NPH       = 3,
    parameter int UW        = 6,
    parameter int TIM_CMAX  = 50000000,
    parameter int END_UNITS = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NPH-1:0]              en_mask,
    input  logic [NPH*UW-1:0]           dur,
    input  logic                        start,
    input  logic                        tr_run,
    input  logic                        tr_abort,
    input  logic                        tr_ack,
    output logic [NPH-1:0]              cur_ph,
    output logic [NPH-1:0]              ld_ph,
    output logic [UW-1:0]               u_cur,
    output logic [calc_tw(NPH, UW)-1:0] u_tot,
    output logic                        busy,
    output logic                        paused,
    output logic                        waiting,
    output logic                        prog_done,
    output logic                        fin,
    output logic                        err
);

    localparam int TW = calc_tw(NPH, UW);
    localparam int EW = (END_UNITS > 1) ? $clog2(END_UNITS) : 1;

    state_t              state_reg, state_next;
    logic [NPH-1:0]      cur_reg, cur_next;
    logic [NPH-1:0]      ld_reg, ld_next;
    logic [UW-1:0]       ucur_reg, ucur_next;
    logic [TW-1:0]       utot_reg, utot_next;
    logic [NPH*UW-1:0]   dur_reg, dur_next;
    logic [EW-1:0]       end_cnt_reg, end_cnt_next;
    logic                done_reg, done_next;
    logic                fin_reg, fin_next;
    logic                err_reg, err_next;

    logic [NPH-1:0]      eff_mask, first_oh, rem_mask, next_oh;
    logic [UW-1:0]       first_dur, next_dur;
    logic [TW-1:0]       sum_eff;
    logic                tick_clr, tick_hold, tick_wrap;

    // A phase takes part only if enabled and given a non-zero duration.
    genvar gi;
    generate
        for (gi = 0; gi < NPH; gi++) begin : g_eff
            assign eff_mask[gi] = en_mask[gi] & (dur[gi*UW +: UW] != '0);
        end
    endgenerate

    // Lowest set bit picks the first phase at start and the next pending phase later.
    assign first_oh = eff_mask & (~eff_mask + NPH'(1));
    assign rem_mask = ld_reg & ~cur_reg;
    assign next_oh  = rem_mask & (~rem_mask + NPH'(1));

    // Duration lookups for the selected phases and the program total.
    always_comb begin
        first_dur = '0;
        next_dur  = '0;
        sum_eff   = '0;
        for (int i = 0; i < NPH; i++) begin
            if (first_oh[i]) first_dur = dur[i*UW +: UW];
            if (next_oh[i])  next_dur  = dur_reg[i*UW +: UW];
            if (eff_mask[i]) sum_eff   = sum_eff + TW'(dur[i*UW +: UW]);
        end
    end

    tick_gen #(
        .CMAX (TIM_CMAX)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .hold  (tick_hold),
        .wrap  (tick_wrap)
    );

    // Next-state and datapath: abort beats tr_run and tick; a wrap lands before a pause.
    always_comb begin
        state_next   = state_reg;
        cur_next     = cur_reg;
        ld_next      = ld_reg;
        ucur_next    = ucur_reg;
        utot_next    = utot_reg;
        dur_next     = dur_reg;
        end_cnt_next = end_cnt_reg;
        done_next    = 1'b0;
        fin_next     = 1'b0;
        err_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (eff_mask == '0) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = ST_RUN;
                        cur_next   = first_oh;
                        ld_next    = eff_mask;
                        ucur_next  = first_dur;
                        utot_next  = sum_eff;
                        dur_next   = dur;
                    end
                end
            end
            ST_RUN: begin
                if (tr_abort) begin
                    state_next = ST_IDLE;
                    cur_next   = '0;
                    ld_next    = '0;
                    ucur_next  = '0;
                    utot_next  = '0;
                end else begin
                    if (tick_wrap) begin
                        utot_next = utot_reg - TW'(1);
                        if (ucur_reg == UW'(1)) begin
                            done_next = 1'b1;
                            ld_next   = rem_mask;
                            cur_next  = next_oh;
                            ucur_next = next_dur;
                            if (rem_mask == '0) begin
                                state_next = ST_END;
                                utot_next  = '0;
                            end
                        end else begin
                            ucur_next = ucur_reg - UW'(1);
                        end
                    end
                    if (tr_run && state_next == ST_RUN) begin
                        state_next = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (tr_abort) begin
                    state_next = ST_IDLE;
                    cur_next   = '0;
                    ld_next    = '0;
                    ucur_next  = '0;
                    utot_next  = '0;
                end else if (tr_run) begin
                    state_next = ST_RUN;
                end
            end
            ST_END: begin
                if (tr_ack) begin
                    state_next   = ST_IDLE;
                    end_cnt_next = '0;
                end else if (tick_wrap) begin
                    if (end_cnt_reg == EW'(END_UNITS - 1)) begin
                        state_next   = ST_IDLE;
                        end_cnt_next = '0;
                        fin_next     = 1'b1;
                    end else begin
                        end_cnt_next = end_cnt_reg + EW'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Timebase restarts from zero for every run and for the end-wait; frozen in PAUSE.
        tick_clr  = (state_reg == ST_IDLE) || (state_next == ST_IDLE) ||
                    (state_reg == ST_RUN && state_next == ST_END);
        tick_hold = (state_reg == ST_PAUSE);
    end

    // State and datapath registers; reset abandons any program without pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cur_reg     <= '0;
            ld_reg      <= '0;
            ucur_reg    <= '0;
            utot_reg    <= '0;
            dur_reg     <= '0;
            end_cnt_reg <= '0;
            done_reg    <= 1'b0;
            fin_reg     <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cur_reg     <= cur_next;
            ld_reg      <= ld_next;
            ucur_reg    <= ucur_next;
            utot_reg    <= utot_next;
            dur_reg     <= dur_next;
            end_cnt_reg <= end_cnt_next;
            done_reg    <= done_next;
            fin_reg     <= fin_next;
            err_reg     <= err_next;
        end
    end

    assign cur_ph    = cur_reg;
    assign ld_ph     = ld_reg;
    assign u_cur     = ucur_reg;
    assign u_tot     = utot_reg;
    assign busy      = (state_reg == ST_RUN);
    assign paused    = (state_reg == ST_PAUSE);
    assign waiting   = (state_reg == ST_END);
    assign prog_done = done_reg;
    assign fin       = fin_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_prog_seq.sv
// Scoreboard bench for prog_seq (NPH=3, UW=6, TIM_CMAX=4, END_UNITS=2).
// Stimulus pushes expected pulse events; a negedge monitor pops and compares.
module tb_prog_seq;

    localparam int NPH = 3;
    localparam int UW  = 6;
    localparam int TW  = 8;

    localparam logic [3:0] C_START = 4'b0001;
    localparam logic [3:0] C_RUN   = 4'b0010;
    localparam logic [3:0] C_ABORT = 4'b0100;
    localparam logic [3:0] C_ACK   = 4'b1000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NPH-1:0]    en_mask = '0;
    logic [NPH*UW-1:0] dur = '0;
    logic              start = 1'b0, tr_run = 1'b0, tr_abort = 1'b0, tr_ack = 1'b0;
    logic [NPH-1:0]    cur_ph, ld_ph;
    logic [UW-1:0]     u_cur;
    logic [TW-1:0]     u_tot;
    logic              busy, paused, waiting, prog_done, fin, err;

    prog_seq #(
        .NPH       (NPH),
        .UW        (UW),
        .TIM_CMAX  (4),
        .END_UNITS (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_mask   (en_mask),
        .dur       (dur),
        .start     (start),
        .tr_run    (tr_run),
        .tr_abort  (tr_abort),
        .tr_ack    (tr_ack),
        .cur_ph    (cur_ph),
        .ld_ph     (ld_ph),
        .u_cur     (u_cur),
        .u_tot     (u_tot),
        .busy      (busy),
        .paused    (paused),
        .waiting   (waiting),
        .prog_done (prog_done),
        .fin       (fin),
        .err       (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 1 prog_done, 2 fin, 3 err
        int          at;
        logic [22:0] snap;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   t0;

    function automatic logic [22:0] mk(input logic [2:0] c, input logic [2:0] l,
                                       input logic [5:0] uc, input logic [7:0] ut,
                                       input logic [2:0] bpw);
        return {c, l, uc, ut, bpw};
    endfunction

    function automatic logic [22:0] snap();
        return {cur_ph, ld_ph, u_cur, u_tot, busy, paused, waiting};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int k, input int at, input logic [22:0] s);
        exp_t e;
        e.kind = k;
        e.at   = at;
        e.snap = s;
        sbq.push_back(e);
    endtask

    task automatic prog(input logic [2:0] m, input logic [5:0] d2, input logic [5:0] d1,
                        input logic [5:0] d0);
        en_mask = m;
        dur     = {d2, d1, d0};
    endtask

    // Drive command bits so they are sampled exactly at posedge number edge_n.
    task automatic cmd(input int edge_n, input logic [3:0] c);
        if (cyc > edge_n - 1) begin
            total++;
            bad++;
            $display("FAIL sched: at cyc %0d required edge %0d", cyc, edge_n);
        end
        while (cyc < edge_n - 1) @(negedge clk);
        {tr_ack, tr_abort, tr_run, start} = c;
        @(posedge clk);
        #1;
        {tr_ack, tr_abort, tr_run, start} = 4'b0000;
    endtask

    task automatic at_cyc(input int n);
        do @(negedge clk); while (cyc < n);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        int   k;
        exp_t e;
        if (prog_done || fin || err) begin
            k = err ? 3 : (fin ? 2 : 1);
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: got kind %0d at cyc %0d, required none", k, cyc);
            end else begin
                e = sbq.pop_front();
                $display("evt kind=%0d cyc=%0d (want kind=%0d cyc=%0d)", k, cyc, e.kind, e.at);
                chk("evt_kind", k, e.kind);
                chk("evt_cyc", cyc, e.at);
                chk("evt_snap", {9'd0, snap()}, {9'd0, e.snap});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {9'd0, snap()}, 32'd0);
        chk("reset_pulses", {prog_done, fin, err}, 32'd0);
        rst_n = 1'b1;

        // Two phases p0=2, p2=3; a second start mid-run is ignored
        prog(3'b101, 6'd3, 6'd5, 6'd2);
        t0 = cyc + 1;
        push_exp(1, t0 + 8,  mk(3'b100, 3'b100, 6'd3, 8'd3, 3'b100));
        push_exp(1, t0 + 20, mk(3'b000, 3'b000, 6'd0, 8'd0, 3'b001));
        push_exp(2, t0 + 28, mk(3'b000, 3'b000, 6'd0, 8'd0, 3'b000));
        cmd(t0, C_START);
        at_cyc(t0);
        chk("t1_start", {9'd0, snap()}, {9'd0, mk(3'b001, 3'b101, 6'd2, 8'd5, 3'b100)});
        prog(3'b111, 6'd7, 6'd7, 6'd7);
        cmd(t0 + 2, C_START);
        at_cyc(t0 + 4);
        chk("t1_unit1", {9'd0, snap()}, {9'd0, mk(3'b001, 3'b101, 6'd1, 8'd4, 3'b100)});
        at_cyc(t0 + 29);
        chk("t1_idle", {9'd0, snap()}, 32'd0);

        // Middle phase has zero duration and is skipped
        prog(3'b111, 6'd2, 6'd0, 6'd1);
        t0 = cyc + 1;
        push_exp(1, t0 + 4,  mk(3'b100, 3'b100, 6'd2, 8'd2, 3'b100));
        push_exp(1, t0 + 12, mk(3'b000, 3'b000, 6'd0, 8'd0, 3'b001));
        push_exp(2, t0 + 20, mk(3'b000, 3'b000, 6'd0, 8'd0, 3'b000));
        cmd(t0, C_START);
        at_cyc(t0);
        chk("t2_start", {9'd0, snap()}, {9'd0, mk(3'b001, 3'b101, 6'd1, 8'd3, 3'b100)});
        at_cyc(t0 + 21);

        // Empty mask, then all-zero durations: err pulse, stays idle
        prog(3'b000, 6'd3, 6'd5, 6'd2);
        t0 = cyc + 1;
        push_exp(3, t0, mk(3'b000, 3'b000, 6'd0, 8'd0, 3'b000));
        cmd(t0, C_START);
        at_cyc(t0 + 1);
        chk("t3a_idle", {9'd0, snap()}, 32'd0);
        prog(3'b111, 6'd0, 6'd0, 6'd0);
        t0 = cyc + 1;
        push_exp(3, t0, mk(3'b000, 3'b000, 6'd0, 8'd0, 3'b000));
        cmd(t0, C_START);
        at_cyc(t0 + 1);
        chk("t3b_idle", {9'd0, snap()}, 32'd0);

        // Pause with tick count frozen at 2, resume, then abort+run together
        prog(3'b001, 6'd0, 6'd0, 6'd5);
        t0 = cyc + 1;
        cmd(t0, C_START);
        at_cyc(t0);
        chk("t4_start", {9'd0, snap()}, {9'd0, mk(3'b001, 3'b001, 6'd5, 8'd5, 3'b100)});
        cmd(t0 + 2, C_RUN);
        at_cyc(t0 + 2);
        chk("t4_paused", {9'd0, snap()}, {9'd0, mk(3'b001, 3'b001, 6'd5, 8'd5, 3'b010)});
        at_cyc(t0 + 11);
        chk("t4_hold", {9'd0, snap()}, {9'd0, mk(3'b001, 3'b001, 6'd5, 8'd5, 3'b010)});
        cmd(t0 + 12, C_RUN);
        at_cyc(t0 + 13);
        chk("t4_resume", {9'd0, snap()}, {9'd0, mk(3'b001, 3'b001, 6'd5, 8'd5, 3'b100)});
        at_cyc(t0 + 14);
        chk("t4_decr", {9'd0, snap()}, {9'd0, mk(3'b001, 3'b001, 6'd4, 8'd4, 3'b100)});
        cmd(t0 + 15, C_ABORT | C_RUN);
        at_cyc(t0 + 15);
        chk("t5_abort", {9'd0, snap()}, 32'd0);
        at_cyc(t0 + 40);
        chk("t5_quiet", {9'd0, snap()}, 32'd0);

        // End-wait acknowledged one clock before expiry
        prog(3'b001, 6'd0, 6'd0, 6'd1);
        t0 = cyc + 1;
        push_exp(1, t0 + 4, mk(3'b000, 3'b000, 6'd0, 8'd0, 3'b001));
        cmd(t0, C_START);
        at_cyc(t0 + 10);
        chk("t6_waiting", {busy, paused, waiting}, 32'b001);
        cmd(t0 + 11, C_ACK);
        at_cyc(t0 + 11);
        chk("t6_ack", {9'd0, snap()}, 32'd0);
        at_cyc(t0 + 20);

        // Ack on the very expiry edge wins: no fin
        t0 = cyc + 1;
        push_exp(1, t0 + 4, mk(3'b000, 3'b000, 6'd0, 8'd0, 3'b001));
        cmd(t0, C_START);
        cmd(t0 + 12, C_ACK);
        at_cyc(t0 + 12);
        chk("t6b_ack", {9'd0, snap()}, 32'd0);
        at_cyc(t0 + 20);

        // Asynchronous reset mid-run
        prog(3'b001, 6'd0, 6'd0, 6'd5);
        t0 = cyc + 1;
        cmd(t0, C_START);
        at_cyc(t0 + 3);
        chk("t7_running", {busy, paused, waiting}, 32'b100);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_async", {9'd0, snap()}, 32'd0);
        chk("t7_pulses", {prog_done, fin, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        at_cyc(cyc + 30);
        chk("t7_quiet", {9'd0, snap()}, 32'd0);

        chk("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
